// File: rtl/uart_pkg.sv
`default_nettype none
// Shared UART definitions: one bit-rate default and the transmitter state set,
// so the receiver and the buffered transmitter always agree.
package uart_pkg;

  localparam int UART_DATA_BITS        = 8;
  localparam int UART_CLK_PER_HALF_BIT = 5208;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// Synchronous first-word fall-through FIFO; dout shows the head whenever not empty.
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == COUNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are serialised
// back-to-back on txd at 2*CLK_PER_HALF_BIT clocks per bit.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = UART_CLK_PER_HALF_BIT,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [UART_DATA_BITS-1:0]   wdata,
  input  logic                        wvalid,
  output logic                        wready,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int CNT_W    = $clog2(BIT_CLKS);
  localparam int IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  tx_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      bit_end;
  logic                      pop;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wvalid & wready),
    .din   (wdata),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wready  = ~fifo_full;
  assign busy    = (state != S_IDLE) | ~fifo_empty;
  assign bit_end = (cnt == CNT_LAST);
  // Loading from the stop bit straight into the next start bit removes any idle gap.
  assign pop     = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & bit_end));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
    end else begin
      cnt <= ((state == S_IDLE) || bit_end) ? '0 : cnt + 1'b1;
      case (state)
        S_IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shreg   <= fifo_dout;
            bit_idx <= '0;
            txd     <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_idx <= '0;
            txd     <= shreg[0];
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_idx == IDX_LAST) begin
              txd   <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shreg[1];
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (pop) begin
              shreg   <= fifo_dout;
              bit_idx <= '0;
              txd     <= 1'b0;
              state   <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
